// File: rtl/pulse_meas_sched.sv
// Time-shares one pulse counter across CH_NUM inputs: per-channel gate, count capture, tagged valid/ready results.
// Build option PMS_GUARD_EN inserts a 2-cycle mux-settle GUARD state between channel select and gate.
module pulse_meas_sched #(
    parameter int CH_W    = 2,
    parameter int CNT_W   = 16,
    parameter int GATE_W  = 24,
    parameter int TIMEOUT = 16,
    localparam int CH_NUM = 1 << CH_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic [CH_NUM-1:0] i_ch_mask,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic [CH_NUM-1:0] i_pulse,
    output logic              o_cnt_pulse,
    output logic              o_cnt_en,
    input  logic              i_cnt_vld,
    input  logic [CNT_W-1:0]  i_cnt_val,
    output logic              o_res_vld,
    input  logic              i_res_rdy,
    output logic [CH_W-1:0]   o_res_ch,
    output logic [CNT_W-1:0]  o_res_cnt,
    output logic              o_res_err,
    output logic              o_busy
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    // state | meaning: IDLE wait start | SEL load ch/gate | GUARD mux settle | GATE counter enabled | WAIT await vld | HOLD present result
`ifdef PMS_GUARD_EN
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_GUARD, S_GATE, S_WAIT, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_SEL, S_GATE, S_WAIT, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [CH_NUM-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
`ifdef PMS_GUARD_EN
    logic              guard_cnt_q, guard_cnt_d;
`endif
    logic              cnt_en_q, cnt_en_d;
    logic              pulse_q, pulse_d;
    logic              res_vld_q, res_vld_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic              res_err_q, res_err_d;
    logic              busy_q, busy_d;

    // Returns {found, index} of the lowest set bit of m at or above lo.
    function automatic logic [CH_W:0] find_set(input logic [CH_NUM-1:0] m, input int lo);
        logic [CH_W:0] r;
        r = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    logic [CH_W:0] start_ch, wrap_ch, next_ch;

    always_comb begin
        start_ch = find_set(i_ch_mask, 0);
        wrap_ch  = find_set(mask_q, 0);
        next_ch  = find_set(mask_q, int'(ch_q) + 1);
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        ch_d       = ch_q;
        gate_cnt_d = gate_cnt_q;
        wait_cnt_d = wait_cnt_q;
`ifdef PMS_GUARD_EN
        guard_cnt_d = guard_cnt_q;
`endif
        res_ch_d   = res_ch_q;
        res_cnt_d  = res_cnt_q;
        res_err_d  = res_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start && start_ch[CH_W]) begin
                    mask_d  = i_ch_mask;
                    ch_d    = start_ch[CH_W-1:0];
                    state_d = S_SEL;
                end
            end
            S_SEL: begin
                // Zero-length gate is stretched to a single cycle.
                gate_cnt_d = (i_gate_len == '0) ? '0 : i_gate_len - GATE_W'(1);
`ifdef PMS_GUARD_EN
                guard_cnt_d = 1'b1;
                state_d     = S_GUARD;
`else
                state_d     = S_GATE;
`endif
            end
`ifdef PMS_GUARD_EN
            S_GUARD: begin
                if (guard_cnt_q == 1'b0) state_d = S_GATE;
                else                     guard_cnt_d = 1'b0;
            end
`endif
            S_GATE: begin
                if (gate_cnt_q == '0) begin
                    wait_cnt_d = TO_W'(TIMEOUT - 1);
                    state_d    = S_WAIT;
                end else begin
                    gate_cnt_d = gate_cnt_q - GATE_W'(1);
                end
            end
            S_WAIT: begin
                if (i_cnt_vld) begin
                    res_cnt_d = i_cnt_val;
                    res_err_d = 1'b0;
                    res_ch_d  = ch_q;
                    state_d   = S_HOLD;
                end else if (wait_cnt_q == '0) begin
                    res_cnt_d = '0;
                    res_err_d = 1'b1;
                    res_ch_d  = ch_q;
                    state_d   = S_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q - TO_W'(1);
                end
            end
            S_HOLD: begin
                if (i_res_rdy) begin
                    if (next_ch[CH_W]) begin
                        ch_d    = next_ch[CH_W-1:0];
                        state_d = S_SEL;
                    end else if (i_continuous && wrap_ch[CH_W]) begin
                        ch_d    = wrap_ch[CH_W-1:0];
                        state_d = S_SEL;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        cnt_en_d  = (state_d == S_GATE);
        res_vld_d = (state_d == S_HOLD);
        pulse_d   = (state_d == S_GATE || state_d == S_WAIT || state_d == S_HOLD) && i_pulse[ch_d];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            gate_cnt_q  <= '0;
            wait_cnt_q  <= '0;
`ifdef PMS_GUARD_EN
            guard_cnt_q <= 1'b0;
`endif
            cnt_en_q    <= 1'b0;
            pulse_q     <= 1'b0;
            res_vld_q   <= 1'b0;
            res_ch_q    <= '0;
            res_cnt_q   <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            gate_cnt_q  <= gate_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
`ifdef PMS_GUARD_EN
            guard_cnt_q <= guard_cnt_d;
`endif
            cnt_en_q    <= cnt_en_d;
            pulse_q     <= pulse_d;
            res_vld_q   <= res_vld_d;
            res_ch_q    <= res_ch_d;
            res_cnt_q   <= res_cnt_d;
            res_err_q   <= res_err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_cnt_en    = cnt_en_q;
    assign o_cnt_pulse = pulse_q;
    assign o_res_vld   = res_vld_q;
    assign o_res_ch    = res_ch_q;
    assign o_res_cnt   = res_cnt_q;
    assign o_res_err   = res_err_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_pulse_meas_sched.sv
// Bench for pulse_meas_sched: periodic pulse sources, a behavioural pulse counter with programmable valid delay,
// and per-scenario tasks comparing results against expectations derived from periods, gate lengths and delays.
module tb_pulse_meas_sched;
    localparam int CH_W    = 2;
    localparam int CH_NUM  = 4;
    localparam int CNT_W   = 16;
    localparam int GATE_W  = 24;
    localparam int TIMEOUT = 16;
`ifdef PMS_GUARD_EN
    localparam int GUARD_LAT = 2;
`else
    localparam int GUARD_LAT = 0;
`endif

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              i_continuous;
    logic [CH_NUM-1:0] i_ch_mask;
    logic [GATE_W-1:0] i_gate_len;
    logic [CH_NUM-1:0] i_pulse;
    logic              o_cnt_pulse;
    logic              o_cnt_en;
    logic              i_cnt_vld;
    logic [CNT_W-1:0]  i_cnt_val;
    logic              o_res_vld;
    logic              i_res_rdy;
    logic [CH_W-1:0]   o_res_ch;
    logic [CNT_W-1:0]  o_res_cnt;
    logic              o_res_err;
    logic              o_busy;

    int total = 0;
    int bad   = 0;

    // Environment state
    int period[CH_NUM];
    int delay_q[$];
    int gate_len_obs  = -1;
    int gates_started = 0;
    int cyc = 0;
    bit en_prev = 1'b0;
    bit pend = 1'b0;
    int run = 0, hits = 0, held = 0, wcyc = 0, cur_d = 1;

    always #5 clk = ~clk;

    pulse_meas_sched #(
        .CH_W(CH_W), .CNT_W(CNT_W), .GATE_W(GATE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_continuous(i_continuous),
        .i_ch_mask(i_ch_mask), .i_gate_len(i_gate_len), .i_pulse(i_pulse),
        .o_cnt_pulse(o_cnt_pulse), .o_cnt_en(o_cnt_en), .i_cnt_vld(i_cnt_vld), .i_cnt_val(i_cnt_val),
        .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy), .o_res_ch(o_res_ch), .o_res_cnt(o_res_cnt),
        .o_res_err(o_res_err), .o_busy(o_busy)
    );

    // Pulse sources plus a behavioural counter: counts pulses while enabled, reports after a queued delay.
    initial begin
        i_pulse   = '0;
        i_cnt_vld = 1'b0;
        i_cnt_val = '0;
        forever begin
            @(negedge clk);
            i_cnt_vld = 1'b0;
            if (o_cnt_en) begin
                run++;
                if (o_cnt_pulse) hits++;
            end
            if (!en_prev && o_cnt_en) gates_started++;
            if (en_prev && !o_cnt_en) begin
                gate_len_obs = run;
                held  = hits;
                run   = 0;
                hits  = 0;
                pend  = 1'b1;
                wcyc  = 0;
                cur_d = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
            end
            if (pend) begin
                wcyc++;
                if (wcyc == cur_d) begin
                    i_cnt_vld = 1'b1;
                    i_cnt_val = CNT_W'(held);
                    pend      = 1'b0;
                end
            end
            en_prev = o_cnt_en;
            cyc++;
            for (int c = 0; c < CH_NUM; c++)
                i_pulse[c] = (period[c] != 0) && (cyc % period[c] == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_res(input int limit, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < limit) begin
            @(negedge clk);
            n++;
            if (o_res_vld) ok = 1'b1;
        end
    endtask

    task automatic ack(input int hold);
        i_res_rdy = 1'b0;
        repeat (hold) @(negedge clk);
        i_res_rdy = 1'b1;
        @(negedge clk);
        i_res_rdy = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_start = 1'b0; i_continuous = 1'b0; i_ch_mask = '0; i_gate_len = '0; i_res_rdy = 1'b0;
        for (int c = 0; c < CH_NUM; c++) period[c] = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({o_cnt_en, o_cnt_pulse, o_res_vld, o_res_err, o_busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got en/pulse/vld/err/busy=%b want 00000",
                     {o_cnt_en, o_cnt_pulse, o_res_vld, o_res_err, o_busy});
        end
        total++;
        if (o_res_ch !== '0 || o_res_cnt !== '0) begin
            bad++;
            $display("FAIL reset_res: got ch=%0d cnt=%0d want 0 0", o_res_ch, o_res_cnt);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int exp_ch[2];
        int exp_cnt[2];
        exp_ch  = '{0, 2};
        exp_cnt = '{10, 5};
        period[0] = 10; period[1] = 3; period[2] = 20; period[3] = 7;
        delay_q.delete();
        delay_q.push_back(3);
        delay_q.push_back(5);
        i_ch_mask = 4'b0101; i_gate_len = 24'd100; i_continuous = 1'b0; i_res_rdy = 1'b1;
        gate_len_obs = -1;
        pulse_start();
        for (int k = 0; k < 2; k++) begin
            wait_res(400, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL basic_wait: result %0d got none want valid within 400 cycles", k);
                i_res_rdy = 1'b0;
                return;
            end
            total++;
            if (o_res_ch !== CH_W'(exp_ch[k]) || o_res_cnt !== CNT_W'(exp_cnt[k]) || o_res_err !== 1'b0) begin
                bad++;
                $display("FAIL basic_res: got ch=%0d cnt=%0d err=%0d want ch=%0d cnt=%0d err=0",
                         o_res_ch, o_res_cnt, o_res_err, exp_ch[k], exp_cnt[k]);
            end
            total++;
            if (gate_len_obs != 100) begin
                bad++;
                $display("FAIL basic_gate: got %0d want 100", gate_len_obs);
            end
            gate_len_obs = -1;
        end
        repeat (2) @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle: got busy=%0d want 0", o_busy);
        end
        i_res_rdy = 1'b0;
    endtask

    task automatic test_latency();
        bit ok;
        int n;
        period[1] = 5;
        delay_q.delete();
        delay_q.push_back(4);
        i_ch_mask = 4'b0010; i_gate_len = 24'd5; i_res_rdy = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        total++;
        if (o_busy !== 1'b1 || o_cnt_en !== 1'b0) begin
            bad++;
            $display("FAIL lat_busy: got busy=%0d en=%0d want busy=1 en=0", o_busy, o_cnt_en);
        end
        for (int g = 0; g < GUARD_LAT; g++) begin
            @(posedge clk);
            #1;
            total++;
            if (o_cnt_en !== 1'b0 || o_cnt_pulse !== 1'b0) begin
                bad++;
                $display("FAIL lat_guard: cycle %0d got en=%0d pulse=%0d want 0 0", g, o_cnt_en, o_cnt_pulse);
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (o_cnt_en !== 1'b1) begin
            bad++;
            $display("FAIL lat_gate_on: got en=%0d want 1", o_cnt_en);
        end
        n = 1;
        while (n < 100) begin
            @(posedge clk);
            #1;
            if (o_cnt_en !== 1'b1) break;
            n++;
        end
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL lat_gate_len: got %0d want 5", n);
        end
        wait_res(100, ok);
        total++;
        if (!ok || o_res_ch !== 2'd1 || o_res_cnt !== 16'd1 || o_res_err !== 1'b0) begin
            bad++;
            $display("FAIL lat_res: got vld=%0d ch=%0d cnt=%0d err=%0d want 1 1 1 0",
                     ok, o_res_ch, o_res_cnt, o_res_err);
        end
        ack(0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mask_zero();
        bit saw_busy, saw_en;
        int g0;
        saw_busy = 1'b0;
        saw_en   = 1'b0;
        g0 = gates_started;
        i_ch_mask = 4'b0000; i_gate_len = 24'd10;
        @(negedge clk);
        i_start = 1'b1;
        repeat (3) @(negedge clk);
        i_start = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_busy |= o_busy;
            saw_en   |= o_cnt_en;
        end
        total++;
        if (saw_busy || saw_en || gates_started != g0) begin
            bad++;
            $display("FAIL mask_zero: got busy_seen=%0d en_seen=%0d gates=%0d want 0 0 0",
                     saw_busy, saw_en, gates_started - g0);
        end
    endtask

    task automatic test_timeout();
        int d, n, lat;
        for (int pass = 0; pass < 2; pass++) begin
            d = (pass == 0) ? TIMEOUT + 1 : TIMEOUT;
            period[0] = 2;
            delay_q.delete();
            delay_q.push_back(d);
            i_ch_mask = 4'b0001; i_gate_len = 24'd8; i_continuous = 1'b0; i_res_rdy = 1'b0;
            pulse_start();
            n = 0;
            while (!o_cnt_en && n < 50) begin @(negedge clk); n++; end
            while (o_cnt_en && n < 100) begin @(negedge clk); n++; end
            lat = 0;
            while (!o_res_vld && lat < 100) begin @(negedge clk); lat++; end
            total++;
            if (lat != TIMEOUT) begin
                bad++;
                $display("FAIL timeout_lat: delay %0d got %0d cycles want %0d", d, lat, TIMEOUT);
            end
            total++;
            if (pass == 0 && (o_res_ch !== 2'd0 || o_res_cnt !== 16'd0 || o_res_err !== 1'b1)) begin
                bad++;
                $display("FAIL timeout_err: got ch=%0d cnt=%0d err=%0d want 0 0 1", o_res_ch, o_res_cnt, o_res_err);
            end else if (pass == 1 && (o_res_ch !== 2'd0 || o_res_cnt !== 16'd4 || o_res_err !== 1'b0)) begin
                bad++;
                $display("FAIL timeout_edge: got ch=%0d cnt=%0d err=%0d want 0 4 0", o_res_ch, o_res_cnt, o_res_err);
            end
            ack(0);
            total++;
            if (o_busy !== 1'b0) begin
                bad++;
                $display("FAIL timeout_idle: got busy=%0d want 0", o_busy);
            end
        end
    endtask

    task automatic test_hold_stall();
        bit ok;
        int g0;
        period[0] = 3; period[2] = 4; period[1] = 5; period[3] = 2;
        delay_q.delete();
        delay_q.push_back(2);
        delay_q.push_back(2);
        i_ch_mask = 4'b0101; i_gate_len = 24'd12; i_continuous = 1'b0; i_res_rdy = 1'b0;
        pulse_start();
        wait_res(200, ok);
        total++;
        if (!ok || o_res_ch !== 2'd0 || o_res_cnt !== 16'd4 || o_res_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_first: got vld=%0d ch=%0d cnt=%0d err=%0d want 1 0 4 0",
                     ok, o_res_ch, o_res_cnt, o_res_err);
        end
        g0 = gates_started;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if (o_res_vld !== 1'b1 || o_res_ch !== 2'd0 || o_res_cnt !== 16'd4 || o_cnt_en !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: cycle %0d got vld=%0d ch=%0d cnt=%0d en=%0d want 1 0 4 0",
                         i, o_res_vld, o_res_ch, o_res_cnt, o_cnt_en);
            end
        end
        total++;
        if (gates_started != g0) begin
            bad++;
            $display("FAIL stall_nogate: got %0d gates want 0", gates_started - g0);
        end
        ack(0);
        wait_res(200, ok);
        total++;
        if (!ok || o_res_ch !== 2'd2 || o_res_cnt !== 16'd3 || o_res_err !== 1'b0) begin
            bad++;
            $display("FAIL stall_next: got vld=%0d ch=%0d cnt=%0d err=%0d want 1 2 3 0",
                     ok, o_res_ch, o_res_cnt, o_res_err);
        end
        ack(0);
    endtask

    task automatic test_continuous();
        bit ok;
        int g0;
        period[3] = 1;
        delay_q.delete();
        for (int i = 0; i < 3; i++) delay_q.push_back(1);
        i_ch_mask = 4'b1000; i_gate_len = 24'd0; i_continuous = 1'b1; i_res_rdy = 1'b0;
        g0 = gates_started;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_res(100, ok);
            total++;
            if (!ok || o_res_ch !== 2'd3 || o_res_cnt !== 16'd1 || o_res_err !== 1'b0 || gate_len_obs != 1) begin
                bad++;
                $display("FAIL cont_res: result %0d got vld=%0d ch=%0d cnt=%0d err=%0d gate=%0d want 1 3 1 0 1",
                         k, ok, o_res_ch, o_res_cnt, o_res_err, gate_len_obs);
            end
            gate_len_obs = -1;
            if (k == 2) i_continuous = 1'b0;
            ack($urandom_range(0, 2));
        end
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL cont_stop: got busy=%0d want 0", o_busy);
        end
        repeat (10) @(negedge clk);
        total++;
        if (gates_started - g0 != 3) begin
            bad++;
            $display("FAIL cont_gates: got %0d want 3", gates_started - g0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw;
        period[0] = 2; period[1] = 3;
        delay_q.delete();
        i_ch_mask = 4'b0011; i_gate_len = 24'd50; i_continuous = 1'b0; i_res_rdy = 1'b1;
        pulse_start();
        n = 0;
        while (!o_cnt_en && n < 50) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        i_rst_n = 1'b0;
        #1;
        total++;
        if (o_cnt_en !== 1'b0 || o_busy !== 1'b0 || o_res_vld !== 1'b0 || o_cnt_pulse !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got en=%0d busy=%0d vld=%0d pulse=%0d want 0 0 0 0",
                     o_cnt_en, o_busy, o_res_vld, o_cnt_pulse);
        end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        saw = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw |= o_res_vld | o_busy | o_cnt_en;
        end
        total++;
        if (saw) begin
            bad++;
            $display("FAIL rst_quiet: got activity after reset want none");
        end
        i_res_rdy = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int per_tab[4];
        int exp_ch[$], exp_cnt[$], exp_err[$];
        int g, d, r;
        per_tab = '{2, 3, 4, 6};
        for (int s = 0; s < 6; s++) begin
            i_ch_mask  = CH_NUM'($urandom_range(1, 15));
            g          = 12 * $urandom_range(1, 3);
            i_gate_len = GATE_W'(g);
            i_continuous = 1'b0;
            i_res_rdy  = 1'b0;
            for (int c = 0; c < CH_NUM; c++) period[c] = per_tab[$urandom_range(0, 3)];
            delay_q.delete();
            exp_ch.delete(); exp_cnt.delete(); exp_err.delete();
            for (int c = 0; c < CH_NUM; c++) begin
                if (i_ch_mask[c]) begin
                    r = $urandom_range(0, 9);
                    d = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT + 1 : $urandom_range(1, TIMEOUT + 2);
                    delay_q.push_back(d);
                    exp_ch.push_back(c);
                    exp_err.push_back(d > TIMEOUT);
                    exp_cnt.push_back((d > TIMEOUT) ? 0 : g / period[c]);
                end
            end
            gate_len_obs = -1;
            pulse_start();
            for (int k = 0; k < exp_ch.size(); k++) begin
                wait_res(g + TIMEOUT + 50, ok);
                total++;
                if (!ok || o_res_ch !== CH_W'(exp_ch[k]) || o_res_cnt !== CNT_W'(exp_cnt[k]) ||
                    o_res_err !== exp_err[k][0] || gate_len_obs != g) begin
                    bad++;
                    $display("FAIL rand_res: scan %0d got vld=%0d ch=%0d cnt=%0d err=%0d gate=%0d want 1 %0d %0d %0d %0d",
                             s, ok, o_res_ch, o_res_cnt, o_res_err, gate_len_obs,
                             exp_ch[k], exp_cnt[k], exp_err[k], g);
                end
                gate_len_obs = -1;
                ack($urandom_range(0, 3));
            end
            total++;
            if (o_busy !== 1'b0) begin
                bad++;
                $display("FAIL rand_idle: scan %0d got busy=%0d want 0", s, o_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_mask_zero();
        test_timeout();
        test_hold_stall();
        test_continuous();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
